// File: rtl/id_ex_operand_stage.sv
// ID/EX register feeding the ALU: captures operands/controls, forwards from EX/MEM and MEM/WB,
// flags load-use hazards. One cycle ID->EX; hold freezes every register, flush/stall insert a bubble.
module id_ex_operand_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hold,
   input  logic          flush,
   input  logic          valid_in,
   input  logic [AW-1:0] rs_addr_in,
   input  logic [AW-1:0] rt_addr_in,
   input  logic [AW-1:0] rd_addr_in,
   input  logic [DW-1:0] rs_data_in,
   input  logic [DW-1:0] rt_data_in,
   input  logic [15:0]   imm16_in,
   input  logic [4:0]    shamt_in,
   input  logic          uses_rs_in,
   input  logic          uses_rt_in,
   input  logic          ALUSrc1_in,
   input  logic          ALUSrc2_in,
   input  logic          ExtOp_in,
   input  logic          LuOp_in,
   input  logic [5:0]    ALUFun_in,
   input  logic          Sign_in,
   input  logic          RegWr_in,
   input  logic          MemRd_in,
   input  logic          MemWr_in,
   input  logic          exmem_regwr,
   input  logic [AW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_regwr,
   input  logic [AW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_result,
   output logic [DW-1:0] A,
   output logic [DW-1:0] B,
   output logic [5:0]    ALUFun,
   output logic          Sign,
   output logic [DW-1:0] store_data,
   output logic [AW-1:0] rd_out,
   output logic          RegWr_out,
   output logic          MemRd_out,
   output logic          MemWr_out,
   output logic          valid_out,
   output logic          load_use_stall
);

   logic          valid_q;
   logic [AW-1:0] rs_addr_q, rt_addr_q, rd_q;
   logic [DW-1:0] rs_q, rt_q;
   logic [15:0]   imm_q;
   logic [4:0]    shamt_q;
   logic          src1_q, src2_q, ext_q, lu_q, sign_q;
   logic [5:0]    fun_q;
   logic          regwr_q, memrd_q, memwr_q;

   logic          wb_hits_rs, wb_hits_rt;
   logic [DW-1:0] fwd_rs, fwd_rt, ext_imm;

   assign load_use_stall = valid_q & memrd_q & (rd_q != '0) & valid_in &
                           ((uses_rs_in & (rd_q == rs_addr_in)) |
                            (uses_rt_in & (rd_q == rt_addr_in)));

   // The regfile write in WB lands on the same edge as capture, so bypass it here.
   assign wb_hits_rs = memwb_regwr & (memwb_rd != '0) & (memwb_rd == rs_addr_in);
   assign wb_hits_rt = memwb_regwr & (memwb_rd != '0) & (memwb_rd == rt_addr_in);

   always_ff @(posedge clk) begin
      if (reset || (!hold && (flush || load_use_stall))) begin
         valid_q   <= 1'b0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         rd_q      <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         imm_q     <= '0;
         shamt_q   <= '0;
         src1_q    <= 1'b0;
         src2_q    <= 1'b0;
         ext_q     <= 1'b0;
         lu_q      <= 1'b0;
         fun_q     <= '0;
         sign_q    <= 1'b0;
         regwr_q   <= 1'b0;
         memrd_q   <= 1'b0;
         memwr_q   <= 1'b0;
      end else if (!hold) begin
         valid_q   <= valid_in;
         rs_addr_q <= rs_addr_in;
         rt_addr_q <= rt_addr_in;
         rd_q      <= rd_addr_in;
         rs_q      <= wb_hits_rs ? memwb_result : rs_data_in;
         rt_q      <= wb_hits_rt ? memwb_result : rt_data_in;
         imm_q     <= imm16_in;
         shamt_q   <= shamt_in;
         src1_q    <= ALUSrc1_in;
         src2_q    <= ALUSrc2_in;
         ext_q     <= ExtOp_in;
         lu_q      <= LuOp_in;
         fun_q     <= ALUFun_in;
         sign_q    <= Sign_in;
         regwr_q   <= RegWr_in;
         memrd_q   <= MemRd_in;
         memwr_q   <= MemWr_in;
      end
   end

   // EX/MEM is the younger producer, so it takes priority over MEM/WB.
   assign fwd_rs = (exmem_regwr && exmem_rd != '0 && exmem_rd == rs_addr_q) ? exmem_result :
                   (memwb_regwr && memwb_rd != '0 && memwb_rd == rs_addr_q) ? memwb_result : rs_q;
   assign fwd_rt = (exmem_regwr && exmem_rd != '0 && exmem_rd == rt_addr_q) ? exmem_result :
                   (memwb_regwr && memwb_rd != '0 && memwb_rd == rt_addr_q) ? memwb_result : rt_q;

   assign ext_imm = lu_q  ? ({{(DW-16){1'b0}}, imm_q} << 16) :
                    ext_q ? {{(DW-16){imm_q[15]}}, imm_q} :
                            {{(DW-16){1'b0}}, imm_q};

   assign A          = src1_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
   assign B          = src2_q ? ext_imm : fwd_rt;
   assign store_data = fwd_rt;
   assign ALUFun     = fun_q;
   assign Sign       = sign_q;
   assign rd_out     = rd_q;
   assign valid_out  = valid_q;
   assign RegWr_out  = valid_q & regwr_q;
   assign MemRd_out  = valid_q & memrd_q;
   assign MemWr_out  = valid_q & memwr_q;

endmodule
